// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } uart_rx_state_t;

    // Rounded clock divider producing the 16x oversample tick.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return (clk_freq + baud_rate * (UART_OVERSAMPLE / 2)) /
               (baud_rate * UART_OVERSAMPLE);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a valid/ready read side; full pushes are dropped
// and flagged unless a pop frees the slot in the same cycle.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             dropped,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready
);
    localparam int unsigned AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axis_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_ok;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_valid = !empty;
    assign pop       = pop_valid && pop_ready;
    assign wr_ok     = push && (!full || pop);
    assign dropped   = push && full && !pop;
    // Gate the read port so tdata reads zero whenever nothing is valid.
    assign pop_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with 16x oversampling, idle-timeout packet framing and an AXIS FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDLE_BITS  = 20,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  err_framing,
    output logic                  err_parity,
    output logic                  err_overflow
);
    localparam int unsigned DIV        = uart_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SUB_W      = $clog2(UART_OVERSAMPLE);
    localparam int unsigned BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned IDLE_TICKS = IDLE_BITS * UART_OVERSAMPLE;
    localparam int unsigned IDLE_W     = $clog2(IDLE_TICKS + 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_axis: CLK_FREQ too low for 16x oversampling of BAUD_RATE");
    end

    uart_rx_state_t        state;
    uart_rx_state_t        state_next;
    logic                  rx_meta;
    logic                  rx_s;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic [SUB_W-1:0]      sub_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  mid_bit;
    logic                  sub_clr;
    logic                  shift_en;
    logic                  start_detect;
    logic                  accept;
    logic                  framing_hit;
    logic [DATA_WIDTH-1:0] stg_data;
    logic                  stg_valid;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  idle_run;
    logic                  timeout;
    logic                  push;
    logic                  fifo_drop;
`ifdef UART_RX_PARITY_EN
    logic                  par_capture;
    logic                  par_flag;
    logic                  parity_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    assign mid_bit = tick && (sub_cnt == SUB_W'(UART_OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        sub_clr      = 1'b0;
        shift_en     = 1'b0;
        start_detect = 1'b0;
        accept       = 1'b0;
        framing_hit  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_capture  = 1'b0;
        parity_hit   = 1'b0;
`endif
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    start_detect = 1'b1;
                    sub_clr      = 1'b1;
                    state_next   = RX_START;
                end
            end
            RX_START: begin
                if (tick && (sub_cnt == SUB_W'(UART_OVERSAMPLE / 2 - 1))) begin
                    if (rx_s) begin
                        state_next = RX_IDLE;
                    end else begin
                        sub_clr    = 1'b1;
                        state_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (mid_bit) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (mid_bit) begin
                    par_capture = 1'b1;
                    state_next  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (mid_bit) begin
                    if (!rx_s) begin
                        framing_hit = 1'b1;
                        state_next  = RX_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (par_flag) begin
                        parity_hit = 1'b1;
                        state_next = RX_IDLE;
`endif
                    end else begin
                        accept     = 1'b1;
                        state_next = RX_IDLE;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (sub_clr)   sub_cnt <= '0;
            else if (tick) sub_cnt <= sub_cnt + SUB_W'(1);
            if (sub_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + BIT_W'(1);
            if (shift_en) shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_flag   <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            if (par_capture) par_flag <= (^shreg) ^ rx_s;
            err_parity <= parity_hit;
        end
    end
`else
    assign err_parity = 1'b0;
`endif

    // A start edge in the final idle tick means the line was not idle long enough.
    assign idle_run = (state == RX_IDLE) && stg_valid && tick && rx_s;
    assign timeout  = idle_run && (idle_cnt == IDLE_W'(IDLE_TICKS - 1));
    assign push     = timeout || (accept && stg_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_data  <= '0;
            stg_valid <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            if (accept) begin
                stg_data  <= shreg;
                stg_valid <= 1'b1;
            end else if (timeout) begin
                stg_valid <= 1'b0;
            end
            if (start_detect || timeout) idle_cnt <= '0;
            else if (idle_run)           idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_framing  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_framing  <= framing_hit;
            err_overflow <= fifo_drop;
        end
    end

    axis_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({timeout, stg_data}),
        .dropped   (fifo_drop),
        .pop_data  ({m_axis_tlast, m_axis_tdata}),
        .pop_valid (m_axis_tvalid),
        .pop_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_uart_rx_axis.sv
// Scoreboard bench for uart_rx_axis at 16 clocks per bit (DIV=1).
module tb_uart_rx_axis;
    localparam int BIT = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       err_framing;
    logic       err_parity;
    logic       err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         got_rd = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         stab_viol = 0;
    int         n_fe = 0;
    int         n_pe = 0;
    int         n_ov = 0;
    int         last_stop = 0;
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    uart_rx_axis #(
        .CLK_FREQ   (1600000),
        .BAUD_RATE  (100000),
        .DATA_WIDTH (8),
        .IDLE_BITS  (20),
        .FIFO_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (rx),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .err_framing   (err_framing),
        .err_parity    (err_parity),
        .err_overflow  (err_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitor: records beats, error pulses and AXIS stability at negedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev_beat))
                    stab_viol++;
                if (m_axis_tvalid === 1'b1 && !prev_valid) rise_cyc = cyc;
                if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
                    got_q.push_back({m_axis_tlast, m_axis_tdata});
                if (err_framing === 1'b1)  n_fe++;
                if (err_parity === 1'b1)   n_pe++;
                if (err_overflow === 1'b1) n_ov++;
                prev_valid = (m_axis_tvalid === 1'b1);
                prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
                prev_beat  = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        step(BIT);
    endtask

    task automatic send_char(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        last_stop = cyc;
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(4);
        rst = 1'b0;
        step(1);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
        n_checks++;
        if (m_axis_tdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata);
        end
        n_checks++;
        if (m_axis_tlast !== 1'b0) begin
            n_fail++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast);
        end
        n_checks++;
        if ({err_framing, err_parity, err_overflow} !== 3'b000) begin
            n_fail++; $display("FAIL reset_err: got %b expected 000", {err_framing, err_parity, err_overflow});
        end
    endtask

    task automatic test_back_to_back;
        int need;
        logic [8:0] e;
        exp_q.push_back({1'b0, 8'h55});
        send_char(8'h55, 1'b1);
        exp_q.push_back({1'b1, 8'hA3});
        send_char(8'hA3, 1'b1);
        need = got_rd + exp_q.size();
        for (int i = 0; i < 1000 && got_q.size() < need; i++) step(1);
        n_checks++;
        if (got_q.size() < need) begin
            n_fail++; $display("FAIL b2b_count: got %0d beats expected %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[got_rd] !== e) begin
                n_fail++; $display("FAIL b2b_beat: got %h expected %h", got_q[got_rd], e);
            end
            got_rd++;
        end
        exp_q.delete();
        // Stop mid-sample lands 10 cycles into the stop bit (2-flop sync + half bit).
        n_checks++;
        if (rise_cyc !== last_stop + 332) begin
            n_fail++; $display("FAIL b2b_tlast_timing: got cycle %0d expected %0d", rise_cyc, last_stop + 332);
        end
        n_checks++;
        if (n_fe + n_pe + n_ov !== 0) begin
            n_fail++; $display("FAIL b2b_errors: got %0d error pulses expected 0", n_fe + n_pe + n_ov);
        end
    endtask

    task automatic test_glitch;
        int errs0;
        errs0 = n_fe + n_pe + n_ov;
        rx = 1'b0;
        step(5);
        rx = 1'b1;
        step(400);
        n_checks++;
        if (got_q.size() !== got_rd) begin
            n_fail++; $display("FAIL glitch_beats: got %0d beats expected 0", got_q.size() - got_rd);
        end
        n_checks++;
        if (n_fe + n_pe + n_ov !== errs0) begin
            n_fail++; $display("FAIL glitch_errors: got %0d expected %0d", n_fe + n_pe + n_ov, errs0);
        end
    endtask

    task automatic test_framing;
        int fe0;
        int need;
        logic [8:0] e;
        fe0 = n_fe;
        send_char(8'h12, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        exp_q.push_back({1'b1, 8'h34});
        send_char(8'h34, 1'b1);
        need = got_rd + exp_q.size();
        for (int i = 0; i < 1000 && got_q.size() < need; i++) step(1);
        n_checks++;
        if (got_q.size() < need) begin
            n_fail++; $display("FAIL framing_count: got %0d beats expected %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[got_rd] !== e) begin
                n_fail++; $display("FAIL framing_beat: got %h expected %h", got_q[got_rd], e);
            end
            got_rd++;
        end
        exp_q.delete();
        step(50);
        n_checks++;
        if (n_fe !== fe0 + 1) begin
            n_fail++; $display("FAIL framing_pulse: got %0d cycles expected %0d", n_fe, fe0 + 1);
        end
        n_checks++;
        if (got_q.size() !== got_rd) begin
            n_fail++; $display("FAIL framing_extra: got %0d extra beats expected 0", got_q.size() - got_rd);
        end
    endtask

    task automatic test_overflow;
        int ov0;
        int need;
        logic [8:0] e;
        logic [7:0] d;
        ov0 = n_ov;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            d = 8'(i);
            if (i < 16) exp_q.push_back({1'b0, d});
            send_char(d, 1'b1);
        end
        for (int i = 0; i < 1000 && n_ov == ov0; i++) step(1);
        step(5);
        n_checks++;
        if (n_ov !== ov0 + 1) begin
            n_fail++; $display("FAIL overflow_pulse: got %0d cycles expected %0d", n_ov, ov0 + 1);
        end
        n_checks++;
        if (got_q.size() !== got_rd) begin
            n_fail++; $display("FAIL overflow_stall: got %0d beats expected 0", got_q.size() - got_rd);
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL overflow_valid_held: got %b expected 1", m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
        need = got_rd + exp_q.size();
        for (int i = 0; i < 200 && got_q.size() < need; i++) step(1);
        n_checks++;
        if (got_q.size() < need) begin
            n_fail++; $display("FAIL overflow_count: got %0d beats expected %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[got_rd] !== e) begin
                n_fail++; $display("FAIL overflow_beat: got %h expected %h", got_q[got_rd], e);
            end
            got_rd++;
        end
        exp_q.delete();
        step(400);
        n_checks++;
        if (got_q.size() !== got_rd) begin
            n_fail++; $display("FAIL overflow_extra: got %0d extra beats expected 0", got_q.size() - got_rd);
        end
        n_checks++;
        if (stab_viol !== 0) begin
            n_fail++; $display("FAIL axis_stability: got %0d violations expected 0", stab_viol);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int pe0;
        int need;
        logic [8:0] e;
        pe0 = n_pe;
        par_flip = 1'b1;
        send_char(8'h07, 1'b1);
        par_flip = 1'b0;
        step(40);
        n_checks++;
        if (n_pe !== pe0 + 1) begin
            n_fail++; $display("FAIL parity_pulse: got %0d cycles expected %0d", n_pe, pe0 + 1);
        end
        exp_q.push_back({1'b1, 8'h07});
        send_char(8'h07, 1'b1);
        need = got_rd + exp_q.size();
        for (int i = 0; i < 1000 && got_q.size() < need; i++) step(1);
        n_checks++;
        if (got_q.size() !== need) begin
            n_fail++; $display("FAIL parity_count: got %0d beats expected %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[got_rd] !== e) begin
                n_fail++; $display("FAIL parity_beat: got %h expected %h", got_q[got_rd], e);
            end
            got_rd++;
        end
        exp_q.delete();
    endtask
`endif

    task automatic test_reset_mid;
        int errs0;
        int need;
        logic [8:0] e;
        logic [7:0] d;
        d = 8'hC3;
        errs0 = n_fe + n_pe + n_ov;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx = d[3];
        step(BIT / 2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        rx = 1'b1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_tvalid: got %b expected 0", m_axis_tvalid);
        end
        step(400);
        n_checks++;
        if (got_q.size() !== got_rd || m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet: got %0d beats tvalid %b expected 0 and 0", got_q.size() - got_rd, m_axis_tvalid);
        end
        n_checks++;
        if (n_fe + n_pe + n_ov !== errs0) begin
            n_fail++; $display("FAIL rstmid_errors: got %0d expected %0d", n_fe + n_pe + n_ov, errs0);
        end
        exp_q.push_back({1'b1, 8'h5A});
        send_char(8'h5A, 1'b1);
        need = got_rd + exp_q.size();
        for (int i = 0; i < 1000 && got_q.size() < need; i++) step(1);
        n_checks++;
        if (got_q.size() !== need) begin
            n_fail++; $display("FAIL rstmid_count: got %0d beats expected %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[got_rd] !== e) begin
                n_fail++; $display("FAIL rstmid_beat: got %h expected %h", got_q[got_rd], e);
            end
            got_rd++;
        end
        exp_q.delete();
    endtask

    initial begin
        rx            = 1'b1;
        rst           = 1'b1;
        m_axis_tready = 1'b1;
        test_reset();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overflow();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
